ram_port_arbiter: RTL and testbench

// - Shares the single RAM_B data port between two bus masters: M0 (SCPU via MIO_BUS) and M1 (DMA/debug loader).
// - Sequences each access as IDLE -> ACCESS -> (WAIT) -> RESP and returns a one-cycle ready pulse to the owner.
// - Sits between MIO_BUS/loader and RAM_B; drives RAM_B wea/addra/dina and captures douta.

---
 rtl/ram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter sharing the RAM_B data port: IDLE -> ACCESS -> (WAIT) -> RESP per access.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build uses fixed M0 priority.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              m0_req,
    input  logic [3:0]        m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic [3:0]        m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic [3:0]        ram_wea,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dina,
    input  logic [DATA_W-1:0] ram_douta,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    localparam logic [2:0] CntInit = 3'(RD_LAT);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [3:0]          we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                win;

    // Winner when at least one request is present (0 = M0, 1 = M1)
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (m0_req && m1_req) begin
            win = ~last_q;
        end else begin
            win = ~m0_req;
        end
`else
        win = ~m0_req;
`endif
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    owner_d = win;
                    we_d    = win ? m1_we    : m0_we;
                    addr_d  = win ? m1_addr  : m0_addr;
                    wdata_d = win ? m1_wdata : m0_wdata;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (we_q != 4'b0000) begin
                    state_d = StResp;
                end else begin
                    cnt_d   = CntInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (owner_q) begin
                        m1_rdata_d = ram_douta;
                    end else begin
                        m0_rdata_d = ram_douta;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            we_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // addr/wdata registers only change at grant, so the RAM bus holds its value outside the access
    assign ram_wea  = (state_q == StAccess) ? we_q : 4'b0000;
    assign ram_addr = addr_q;
    assign ram_dina = wdata_q;
    assign busy     = (state_q != StIdle);
    assign owner    = owner_q;
    assign m0_ready = (state_q == StResp) && !owner_q;
    assign m1_ready = (state_q == StResp) && owner_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: RD_LAT=1 main instance with byte-write RAM model,
// plus RD_LAT=3 and RD_LAT=7 instances on a fixed-pattern pipelined read model.
module tb_ram_port_arbiter;

    logic        clk;
    logic        RSTN;
    logic        m0_req, m1_req;
    logic [3:0]  m0_we, m1_we;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;

    // Main instance, RD_LAT=1
    logic [31:0] a_m0_rdata, a_m1_rdata, a_dina, a_douta;
    logic        a_m0_ready, a_m1_ready, a_busy, a_owner;
    logic [3:0]  a_wea;
    logic [9:0]  a_addr;
    // RD_LAT=3
    logic [31:0] b_m0_rdata, b_m1_rdata, b_dina, b_douta;
    logic        b_m0_ready, b_m1_ready, b_busy, b_owner;
    logic [3:0]  b_wea;
    logic [9:0]  b_addr;
    // RD_LAT=7
    logic [31:0] c_m0_rdata, c_m1_rdata, c_dina, c_douta;
    logic        c_m0_ready, c_m1_ready, c_busy, c_owner;
    logic [3:0]  c_wea;
    logic [9:0]  c_addr;

    int n_cmp = 0;
    int n_err = 0;

    ram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) u_a (
        .clk(clk), .RSTN(RSTN),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(a_m0_rdata), .m0_ready(a_m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(a_m1_rdata), .m1_ready(a_m1_ready),
        .ram_wea(a_wea), .ram_addr(a_addr), .ram_dina(a_dina), .ram_douta(a_douta),
        .busy(a_busy), .owner(a_owner)
    );

    ram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(3)) u_b (
        .clk(clk), .RSTN(RSTN),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(b_m0_rdata), .m0_ready(b_m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(b_m1_rdata), .m1_ready(b_m1_ready),
        .ram_wea(b_wea), .ram_addr(b_addr), .ram_dina(b_dina), .ram_douta(b_douta),
        .busy(b_busy), .owner(b_owner)
    );

    ram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(7)) u_c (
        .clk(clk), .RSTN(RSTN),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(c_m0_rdata), .m0_ready(c_m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(c_m1_rdata), .m1_ready(c_m1_ready),
        .ram_wea(c_wea), .ram_addr(c_addr), .ram_dina(c_dina), .ram_douta(c_douta),
        .busy(c_busy), .owner(c_owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte-enabled single-cycle RAM, read-before-write
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[3] = 32'h11223344;
    end
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (a_wea[b]) mem[a_addr][8*b +: 8] <= a_dina[8*b +: 8];
        end
        a_douta <= mem[a_addr];
    end

    function automatic logic [31:0] pat(input logic [9:0] a);
        return 32'h5A000000 ^ {22'h0, a};
    endfunction

    // Pipelined read-only pattern RAMs for the long-latency instances
    logic [31:0] p3 [0:2];
    logic [31:0] p7 [0:6];
    always @(posedge clk) begin
        p3[0] <= pat(b_addr);
        for (int i = 1; i < 3; i++) p3[i] <= p3[i-1];
        p7[0] <= pat(c_addr);
        for (int i = 1; i < 7; i++) p7[i] <= p7[i-1];
    end
    assign b_douta = p3[2];
    assign c_douta = p7[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int          n_ev;
    logic [1:0]  ev [0:7];
    logic        seen;
    int          rdy_at;
    int          n_busy;
    logic        wea_seen;

    initial begin
        RSTN = 1'b0;
        m0_req = 1'b0; m0_we = 4'h0; m0_addr = 10'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 4'h0; m1_addr = 10'h0; m1_wdata = 32'h0;
        for (int i = 0; i < 8; i++) ev[i] = 2'bxx;
        #2;
        chk("rst_busy", a_busy, 0);
        chk("rst_m0_ready", a_m0_ready, 0);
        chk("rst_m1_ready", a_m1_ready, 0);
        chk("rst_m0_rdata", a_m0_rdata, 0);
        chk("rst_m1_rdata", a_m1_rdata, 0);
        chk("rst_wea", a_wea, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_dina", a_dina, 0);
        chk("rst_owner", a_owner, 0);
        step(); step();
        RSTN = 1'b1;
        step();

        // M0 full-word write
        m0_req = 1'b1; m0_we = 4'hF; m0_addr = 10'h005; m0_wdata = 32'hDEADBEEF;
        step();
        chk("wr_access_wea", a_wea, 4'hF);
        chk("wr_access_addr", a_addr, 10'h005);
        chk("wr_access_dina", a_dina, 32'hDEADBEEF);
        chk("wr_access_busy", a_busy, 1);
        chk("wr_access_noready", a_m0_ready, 0);
        m0_req = 1'b0; m0_we = 4'h0; m0_addr = 10'h0; m0_wdata = 32'h0;
        step();
        chk("wr_resp_m0_ready", a_m0_ready, 1);
        chk("wr_resp_m1_ready", a_m1_ready, 0);
        chk("wr_resp_wea", a_wea, 0);
        step();
        chk("wr_idle_ready", a_m0_ready, 0);
        chk("wr_idle_busy", a_busy, 0);
        chk("wr_idle_addr_hold", a_addr, 10'h005);

        // M0 read back
        m0_req = 1'b1; m0_we = 4'h0; m0_addr = 10'h005;
        step();
        chk("rd_access_wea", a_wea, 0);
        m0_req = 1'b0;
        step();
        chk("rd_wait_noready", a_m0_ready, 0);
        step();
        chk("rd_resp_ready", a_m0_ready, 1);
        chk("rd_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_rdata_unchanged", a_m1_rdata, 0);
        chk("rd_owner", a_owner, 0);
        step();

        // M1 byte write then read back
        m1_req = 1'b1; m1_we = 4'b0010; m1_addr = 10'h003; m1_wdata = 32'h0000AB00;
        step();
        chk("bw_wea", a_wea, 4'b0010);
        chk("bw_owner", a_owner, 1);
        m1_req = 1'b0; m1_we = 4'h0;
        step();
        chk("bw_m1_ready", a_m1_ready, 1);
        chk("bw_m0_ready", a_m0_ready, 0);
        chk("bw_m1_rdata_unchanged", a_m1_rdata, 0);
        step();
        m1_req = 1'b1; m1_addr = 10'h003; m1_we = 4'h0;
        step();
        m1_req = 1'b0;
        step();
        step();
        chk("bw_rd_ready", a_m1_ready, 1);
        chk("bw_rd_data", a_m1_rdata, 32'h1122AB44);
        chk("bw_m0_rdata_held", a_m0_rdata, 32'hDEADBEEF);
        step();

        // Both masters reading continuously
        m0_req = 1'b1; m0_addr = 10'h005; m1_req = 1'b1; m1_addr = 10'h003;
        n_ev = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("one_ready", a_m0_ready & a_m1_ready, 0);
            if (a_m0_ready && n_ev < 8) begin ev[n_ev] = 2'd0; n_ev++; end
            if (a_m1_ready && n_ev < 8) begin ev[n_ev] = 2'd1; n_ev++; end
        end
        chk("arb_count", n_ev, 4);
`ifdef ARB_ROUND_ROBIN_EN
        chk("arb_g0", ev[0], 0);
        chk("arb_g1", ev[1], 1);
        chk("arb_g2", ev[2], 0);
        chk("arb_g3", ev[3], 1);
`else
        chk("arb_g0", ev[0], 0);
        chk("arb_g1", ev[1], 0);
        chk("arb_g2", ev[2], 0);
        chk("arb_g3", ev[3], 0);
`endif
        m0_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_m1_ready) begin
                seen = 1'b1;
                m1_req = 1'b0;
                break;
            end
        end
        chk("arb_m1_served", seen, 1);
        chk("arb_m1_rdata", a_m1_rdata, 32'h1122AB44);
        m1_req = 1'b0;
        step();

        // RD_LAT=3: reset during WAIT, then pending M1 read completes
        RSTN = 1'b0; step(); RSTN = 1'b1; step();
        m1_req = 1'b1; m1_we = 4'h0; m1_addr = 10'h0AA;
        step(); step(); step();
        RSTN = 1'b0;
        #1;
        chk("lat3_rst_busy", b_busy, 0);
        chk("lat3_rst_wea", b_wea, 0);
        chk("lat3_rst_ready", b_m1_ready, 0);
        chk("lat3_rst_addr", b_addr, 0);
        chk("lat3_rst_dina", b_dina, 0);
        chk("lat3_rst_owner", b_owner, 0);
        step();
        chk("lat3_held_ready", b_m1_ready, 0);
        step();
        RSTN = 1'b1;
        rdy_at = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (b_m1_ready && rdy_at == 0) begin
                rdy_at = i;
                m1_req = 1'b0;
            end
        end
        chk("lat3_ready_cycle", rdy_at, 5);
        chk("lat3_m1_rdata", b_m1_rdata, pat(10'h0AA));
        m1_req = 1'b0;

        // RD_LAT=7 read latency and busy duration
        RSTN = 1'b0; step(); RSTN = 1'b1; step();
        chk("lat7_idle_dina", c_dina, 0);
        m0_req = 1'b1; m0_we = 4'h0; m0_addr = 10'h007;
        rdy_at = 0; n_busy = 0; wea_seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) m0_req = 1'b0;
            if (c_busy) n_busy++;
            if (c_wea != 4'h0) wea_seen = 1'b1;
            if (c_m0_ready && rdy_at == 0) rdy_at = i;
        end
        chk("lat7_ready_cycle", rdy_at, 9);
        chk("lat7_busy_cycles", n_busy, 9);
        chk("lat7_no_wea", wea_seen, 0);
        chk("lat7_m0_rdata", c_m0_rdata, pat(10'h007));
        chk("lat7_m1_ready_idle", c_m1_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
